// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX/TX blocks and their buffers.
package uart_pkg;

  localparam int FRAME_SIZE = 8;

  typedef logic [FRAME_SIZE-1:0] uart_frame_t;

endpackage

// File: rtl/pulse_sync.sv
// Brings an asynchronous level/pulse into clk and emits a one-cycle strobe per rising edge.
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_pulse,
  output logic push
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] prime_reg;
  logic                   history_reg;
  logic                   push_reg;
  logic                   sync_out;
  logic                   primed;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign primed   = prime_reg[SYNC_STAGES-1];
  assign push     = push_reg;

  // History is pinned high until the chain has flushed its reset zeros, so a
  // pulse already high at reset release never looks like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      prime_reg   <= '0;
      history_reg <= 1'b1;
      push_reg    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], async_pulse};
      prime_reg   <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
      history_reg <= primed ? sync_out : 1'b1;
      push_reg    <= sync_out & ~history_reg;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive FIFO behind the UART RX block, with sticky overflow flag.
// Define UART_RX_FIFO_DROP_COUNT_EN to add a saturating 16-bit drop_count output.
module uart_rx_fifo #(
  parameter int FRAME_SIZE  = uart_pkg::FRAME_SIZE,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FRAME_SIZE-1:0]      rx_data,
  input  logic                       rx_complete,
  output logic [FRAME_SIZE-1:0]      rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
`ifdef UART_RX_FIFO_DROP_COUNT_EN
  output logic [15:0]                drop_count,
`endif
  input  logic                       overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FRAME_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic                  push;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  pulse_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pulse_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .async_pulse (rx_complete),
    .push        (push)
  );

  assign full     = (count_reg == CW'(DEPTH));
  assign rd_valid = (count_reg != '0);
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;

  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign pop    = rd_valid & rd_ready;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (overflow_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count_reg;

  assign drop_count = drop_count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
    end else if (overflow_clr) begin
      drop_count_reg <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed sequence with random data/consumer against a queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int FS    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FS-1:0] rx_data;
  logic          rx_complete;
  logic [FS-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic          overflow_clr;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .FRAME_SIZE  (FS),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_complete  (rx_complete),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    .drop_count   (drop_count),
`endif
    .overflow_clr (overflow_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: stored frames in order, sticky flag, drop counter and
  // the number of clock edges left until the pending frame is written.
  logic [FS-1:0] q[$];
  bit            m_overflow;
  int            m_dc;
  int            due;
  logic [FS-1:0] cur_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("rd_valid", 32'(rd_valid), 32'(q.size() != 0));
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_overflow));
    if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_dc));
`endif
  endtask

  // Called at a falling edge: check state, drive inputs, advance model over the next rising edge.
  // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the push edge.
  // clr_mode: 0 none, 1 clear on the push edge, 2 clear this cycle.
  task automatic tick(input int mode, input int clr_mode);
    bit push_now, pop_now, rdy, clr, dropped;
    check_outputs();
    push_now = (due == 1);
    case (mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      2:       rdy = 1'($urandom_range(0, 1));
      default: rdy = push_now;
    endcase
    clr = (clr_mode == 2) || (clr_mode == 1 && push_now);
    rd_ready     = rdy;
    overflow_clr = clr;
    pop_now = rdy && (q.size() != 0);
    dropped = push_now && (q.size() == DEPTH) && !pop_now;
    if (pop_now) void'(q.pop_front());
    if (push_now && !dropped) q.push_back(cur_data);
    if (dropped) m_overflow = 1'b1;
    else if (clr) m_overflow = 1'b0;
    if (clr) m_dc = dropped ? 1 : 0;
    else if (dropped && m_dc < 65535) m_dc++;
    if (due != 0) due--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [FS-1:0] d, input int hold, input int low,
                      input int mode, input int clr_mode);
    rx_data     = d;
    cur_data    = d;
    rx_complete = 1'b1;
    due         = LAT;
    repeat (hold) tick(mode, clr_mode);
    rx_complete = 1'b0;
    repeat (low) tick(mode, clr_mode);
  endtask

  task automatic do_reset(input bit rxc);
    rst_n        = 1'b0;
    rx_complete  = rxc;
    rd_ready     = 1'b0;
    overflow_clr = 1'b0;
    q.delete();
    m_overflow = 1'b0;
    m_dc       = 0;
    due        = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rx_data = '0;
    cur_data = '0;
    do_reset(1'b0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    repeat (4) tick(0, 0);

    // Single frame held high for 64 clocks, then one read.
    send(8'hA5, 64, 4, 0, 0);
    chk("single_count", 32'(count), 32'd1);
    tick(1, 0);
    tick(0, 0);

    // Ordering and pointer wrap with a random consumer.
    for (int i = 0; i < 40; i++) send(8'(i), 3, 4, 2, 0);
    repeat (20) tick(1, 0);
    chk("order_overflow", 32'(overflow), 32'd0);

    // Overflow: 17 frames with no consumer.
    do_reset(1'b0);
    repeat (4) tick(0, 0);
    for (int i = 0; i < 17; i++) send(8'($urandom), 3, 4, 0, 0);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    repeat (16) tick(1, 0);
    tick(0, 0);

    // Clear coincident with a drop keeps the flag; a lone clear drops it.
    for (int i = 0; i < 16; i++) send(8'($urandom), 3, 4, 0, 0);
    send(8'($urandom), 3, 4, 0, 1);
    chk("clr_with_drop", 32'(overflow), 32'd1);
    tick(0, 2);
    tick(0, 0);
    chk("clr_alone", 32'(overflow), 32'd0);

    // Push into a full FIFO with a simultaneous pop.
    send(8'($urandom), 3, 4, 3, 0);
    chk("full_pushpop_count", 32'(count), 32'(DEPTH));
    repeat (17) tick(1, 0);

    // Reset mid-operation with five entries stored.
    for (int i = 0; i < 5; i++) send(8'($urandom), 3, 4, 0, 0);
    chk("pre_reset_count", 32'(count), 32'd5);
    do_reset(1'b0);
    tick(0, 0);
    repeat (4) tick(0, 0);

    // rx_complete held high across reset release must not push.
    do_reset(1'b1);
    repeat (10) tick(0, 0);
    rx_complete = 1'b0;
    repeat (5) tick(0, 0);
    send(8'($urandom), 3, 4, 0, 0);
    tick(1, 0);
    tick(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART RX state machine.
- Captures each completed frame, signalled by the RX block's `rx_complete` pulse and `rx_data` word, into a FIFO in the system `clk` domain.
- Presents the frames to the consumer through a first-word-fall-through ready/valid interface.
- Decouples the slow, divided RX clock domain from consumer logic and flags lost frames.

Parameters:
- FRAME_SIZE, 8, data bits per frame; must match the RX block.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- SYNC_STAGES, 2, synchroniser flops on `rx_complete`; >= 2.

Ports:
- clk  input  1  system clock; the same clock that feeds the RX block's clock divider.
- rst_n  input  1  synchronous, active-low reset.
- rx_data  input  FRAME_SIZE  frame word from the RX block; quasi-static, stable for >= 1 frame time after `rx_complete` rises.
- rx_complete  input  1  frame-done pulse from the RX block, one RX-clock period wide, asynchronous to `clk` phase.
- rd_data  output  FRAME_SIZE  oldest stored frame; valid when `rd_valid` = 1.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  consumer accepts `rd_data` this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a frame was dropped.
- overflow_clr  input  1  clears `overflow`.

Behaviour:
- Clocking and reset:
  - Single clock `clk`.
  - Reset is synchronous and active-low on `rst_n`; all state is sampled at `posedge clk`.
- Reset values:
  - rd_valid=0, count=0, full=0, overflow=0, rd_data=0.
  - Read/write pointers 0; synchroniser flops 0.
  - Edge-history flop resets to 1, so an `rx_complete` already high at reset release is ignored.
- Capture path:
  - `rx_complete` passes through SYNC_STAGES flops.
  - A registered rising-edge detect (sync_out & ~history) produces a one-cycle `push` strobe.
  - `rx_data` is sampled on the push cycle without synchronisation; it is legal because the RX data register is stable long before and after the pulse.
  - A pulse held high for many `clk` cycles produces exactly one push.
- Latency:
  - `rx_complete` rising before `clk` edge 0 gives push asserted in cycle SYNC_STAGES+1.
  - The entry is written on that edge; `rd_valid`=1 and `rd_data` are correct from cycle SYNC_STAGES+2.
  - Default: 4 clocks.
- Read interface:
  - FWFT: `rd_data` = mem[rd_ptr] whenever `rd_valid`=1.
  - Pop = rd_valid & rd_ready; `rd_ptr` increments on pop.
  - `rd_ready` while empty has no effect.
- Pointers:
  - $clog2(DEPTH) bits, natural wrap at DEPTH.
  - `count` maintained by a separate up/down counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- Boundary conditions:
  - Push while full with simultaneous pop: accepted; count stays DEPTH.
  - Push while full without pop: frame dropped, pointers unchanged, `overflow` set.
  - Push while empty: `rd_valid` rises the next cycle; there is no same-cycle bypass.
  - `overflow_clr` together with a new drop: set wins, `overflow` stays 1.
  - Reset mid-operation: FIFO contents are discarded; memory array contents are don't-care and not reset.
- Outputs `full`, `rd_valid` and `count` are registered or derived from registered state only; no combinational path from `rd_ready` to `rd_valid`.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_COUNT_EN.
- Defined:
  - Adds output `drop_count`, 16 bits.
  - Increments once per dropped frame and saturates at 16'hFFFF.
  - Cleared by `overflow_clr` (increment wins on the same cycle, giving 1) and reset to 0.
- Undefined: port and counter absent; `overflow` behaviour is unchanged.

Decomposition:
- Package `uart_pkg`:
  - Localparam default FRAME_SIZE=8, shared with the RX/TX blocks.
  - `uart_frame_t` typedef, logic [FRAME_SIZE-1:0].
- Sub-module `pulse_sync`:
  - Parameter SYNC_STAGES; contains the synchroniser chain, history flop and rising-edge detect.
  - Output is a one-cycle `push` pulse; reused later by the TX-done path.
- FIFO storage and pointers stay in `uart_rx_fifo`.

Test Plan:
- Single frame: after reset, rx_data=8'hA5, `rx_complete` high for 64 clk -> exactly one push; rd_valid=1 exactly 4 clk after the rise; rd_data=8'hA5, count=1; rd_ready=1 for one cycle -> rd_valid=0, count=0.
- Ordering/wrap: 40 frames 8'h00..8'h27, consumer draining with random rd_ready -> output sequence 8'h00..8'h27 in order; pointers wrap twice; overflow=0.
- Overflow: 17 frames with rd_ready=0 (DEPTH=16) -> full=1, count=16, overflow=1; reads return first 16 values, 17th lost; with UART_RX_FIFO_DROP_COUNT_EN, drop_count=1.
- Full with simultaneous push/pop: fill to 16, hold rd_ready=1 during the next push -> count stays 16, overflow=0, new frame appears last.
- Clear priority: overflow_clr pulsed on the same cycle as a drop -> overflow=1; pulsed alone later -> overflow=0 (drop_count=0).
- Reset: `rx_complete` held high across rst_n release -> no push. rst_n low for one cycle with count=5 -> count=0, rd_valid=0, full=0 next cycle.
